// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: arbiter FSM encoding and byte width.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner select: first requester at or after i_ptr+1, wrapping.
// Purely combinational; o_any flags that some requester is asking.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!o_any && i_req[cand]) begin
                o_any       = 1'b1;
                o_gnt[cand] = 1'b1;
                o_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte sources, with optional guard gap.
// Optional UART_TX_ARB_LOCK_EN adds i_Req_Lock to keep ownership for multi-byte messages.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int GAP_CLKS = 0,
    parameter int GAP_W    = 8
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_L,
    input  logic [NUM_REQ-1:0]             i_Req,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_Req_Byte,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             i_Req_Lock,
`endif
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic [NUM_REQ-1:0]             o_Ack,
    output logic                           o_Tx_DV,
    output logic [UART_BYTE_W-1:0]         o_Tx_Byte,
    input  logic                           i_Tx_Active,
    input  logic                           i_Tx_Done,
    output logic                           o_Busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [UART_BYTE_W-1:0] byte_q, byte_d;
    logic                   dv_q, dv_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [NUM_REQ-1:0]     ack_c;

    logic [NUM_REQ-1:0]     rr_gnt, win_gnt;
    logic [IDX_W-1:0]       rr_idx, win_idx;
    logic                   rr_any, win_any;

    uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req (i_Req),
        .i_ptr (ptr_q),
        .o_gnt (rr_gnt),
        .o_idx (rr_idx),
        .o_any (rr_any)
    );

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_q, lock_d;

    // A locked owner that is still asking jumps the round-robin order.
    always_comb begin
        win_gnt = rr_gnt;
        win_idx = rr_idx;
        win_any = rr_any;
        if (lock_q && i_Req[owner_q]) begin
            win_gnt = NUM_REQ'(1) << owner_q;
            win_idx = owner_q;
            win_any = 1'b1;
        end
    end
`else
    always_comb begin
        win_gnt = rr_gnt;
        win_idx = rr_idx;
        win_any = rr_any;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gap_d   = gap_q;
        ack_c   = '0;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_any && !i_Tx_Active) begin
                    grant_d = win_gnt;
                    byte_d  = i_Req_Byte[{win_idx, 3'b000} +: UART_BYTE_W];
                    owner_d = win_idx;
                    dv_d    = 1'b1;
                    state_d = ST_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end
            end
            ST_ISSUE: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    ack_c   = grant_q;
                    grant_d = '0;
                    gap_d   = '0;
                    state_d = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                    if (|(i_Req_Lock & grant_q)) lock_d = 1'b1;
                    else                         ptr_d  = owner_q;
`else
                    ptr_d   = owner_q;
`endif
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            ptr_q   <= PTR_RST;
            owner_q <= '0;
            gap_q   <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gap_q   <= gap_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    // Ack is combinational so it lands in the i_Tx_Done cycle; suppressed during reset.
    assign o_Ack     = i_Rst_L ? ack_c : '0;
    assign o_Grant   = grant_q;
    assign o_Tx_DV   = dv_q;
    assign o_Tx_Byte = byte_q;
    assign o_Busy    = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte-producing requesters using round-robin arbitration.
- Sequences each transfer: grant, a one-cycle i_Tx_DV pulse into uart_tx, wait for o_Tx_Done, acknowledge the requester, then an optional inter-byte guard gap.
- Sits between the on-chip message sources and uart_tx; uart_tx itself is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- GAP_CLKS, 0, idle clocks inserted after each o_Tx_Done before the next issue; 0 = no gap
- GAP_W, 8, width of the gap counter; GAP_CLKS must be < 2**GAP_W

Ports:
- i_Clock  in  1  system clock
- i_Rst_L  in  1  synchronous active-low reset
- i_Req  in  NUM_REQ  per-requester request, level
- i_Req_Byte  in  8*NUM_REQ  packed bytes; requester k uses bits [8k+7:8k]
- o_Grant  out  NUM_REQ  one-hot current owner; all zero when idle
- o_Ack  out  NUM_REQ  one-cycle pulse to the owner when its byte has fully transmitted
- o_Tx_DV  out  1  to uart_tx i_Tx_DV
- o_Tx_Byte  out  8  to uart_tx i_Tx_Byte
- i_Tx_Active  in  1  from uart_tx o_Tx_Active
- i_Tx_Done  in  1  from uart_tx o_Tx_Done
- o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset: i_Clock only, sampled when i_Rst_L=0. Reset values:
  - o_Grant=0, o_Ack=0, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0
  - state=IDLE, gap counter=0, round-robin pointer=NUM_REQ-1, so requester 0 wins first.
- States:
  - IDLE: if any i_Req is high and i_Tx_Active=0, pick the winner (first requester at or after pointer+1, wrapping). Register o_Grant one-hot, register o_Tx_Byte from that requester's byte, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: o_Tx_DV=1 for exactly this one cycle; go to WAIT_DONE.
  - WAIT_DONE: hold o_Grant. When i_Tx_Done=1: pulse o_Ack for the owner that cycle, set pointer=owner index, clear o_Grant, then go to GAP if GAP_CLKS>0, else to IDLE.
  - GAP: count GAP_CLKS cycles, then go to IDLE.
- Latency: a request seen in IDLE at cycle N gives o_Grant and o_Tx_Byte valid at N+1 and o_Tx_DV high at N+1.
- Byte capture: the byte is captured in the IDLE→ISSUE transition. The requester only needs it stable during that cycle.
- Requester handshake: the requester must hold i_Req until o_Ack. Deasserting i_Req after the grant does not abort the transfer; the byte is still sent and acked.
- Requester holding i_Req high after o_Ack: treated as a new request, arbitrated fairly against the others.
- Transmitter still active: if i_Tx_Active=1 while in IDLE (e.g. after a reset mid-frame, since uart_tx has no reset), no issue happens until it drops.
- i_Tx_Done outside WAIT_DONE: ignored.
- Simultaneous requests: strict round-robin. With all NUM_REQ requesting continuously, each gets exactly one byte per NUM_REQ transfers.
- Reset mid-operation (any state): return to the reset values on the next edge. No o_Ack is issued for the interrupted byte.
- o_Ack and o_Grant: never more than one bit set at a time.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- When defined:
  - Adds port i_Req_Lock (in, NUM_REQ).
  - If the owner's i_Req_Lock bit is 1 in the o_Ack cycle, the pointer is not advanced.
  - On the next IDLE decision, the same requester is granted if its i_Req is high, giving atomic multi-byte messages.
  - If it is not requesting, normal round-robin resumes.
- When undefined: no port, pure round-robin.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams ST_IDLE, ST_ISSUE, ST_WAIT_DONE, ST_GAP (2 bits)
  - UART_BYTE_W=8
- Sub-module uart_rr_pick: combinational. Inputs are the request vector and pointer; outputs are the one-hot winner and its index.

Test Plan:
- Single request: CLKS_PER_BIT=87, GAP_CLKS=0, i_Req[0]=1 with byte 8'hAB → o_Grant=4'b0001 and o_Tx_DV pulse one cycle later; uart_tx serialises 0xAB; o_Ack[0] in the i_Tx_Done cycle.
- Fair rotation: all four requesting continuously with bytes 11/22/33/44 → transmit order 0x11,0x22,0x33,0x44,0x11; exactly one o_Ack per byte.
- Gap: GAP_CLKS=20 → exactly 20 cycles between the o_Ack cycle and the next o_Tx_DV+1 (measured from leaving GAP), with o_Busy high throughout.
- Reset mid-frame: i_Rst_L low for 2 cycles during WAIT_DONE while uart_tx is still active → all outputs at reset values, no o_Ack; the next issue waits for i_Tx_Active=0.
- Early deassert: i_Req[2] dropped one cycle after grant → the byte is still transmitted and o_Ack[2] still pulses.
- Lock (UART_TX_ARB_LOCK_EN): requester 1 locks for 3 bytes while requester 0 also requests → bytes go 1,1,1 then 0; without the macro they alternate 0/1.
